// File: rtl/sram_arbiter.sv
// N-master Wishbone-lite to single-port SRAM arbiter with registered one-hot grant,
// round-robin or fixed-priority selection, byte-to-word address shift and a bus watchdog.
module sram_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int ADDR_SHIFT  = 2,
    parameter int RR_MODE     = 1,
    parameter int TIMEOUT     = 255
) (
    input  logic                        clk,
    input  logic                        i_rst_n,
    input  logic [NUM_MASTERS-1:0]      i_m_cyc,
    input  logic [NUM_MASTERS-1:0]      i_m_we,
    input  logic [NUM_MASTERS*AW-1:0]   i_m_adr,
    input  logic [NUM_MASTERS*DW-1:0]   i_m_dat,
    input  logic [NUM_MASTERS*DW/8-1:0] i_m_sel,
    output logic [DW-1:0]               o_m_rdt,
    output logic [NUM_MASTERS-1:0]      o_m_ack,
    output logic [NUM_MASTERS-1:0]      o_m_err,
    output logic [AW-1:0]               o_sram_addr,
    output logic [DW-1:0]               o_sram_wdata,
    output logic [DW/8-1:0]             o_sram_wmask,
    output logic                        o_sram_we,
    output logic                        o_sram_cs,
    input  logic [DW-1:0]               i_sram_rdata,
    input  logic                        i_sram_ack,
    output logic [NUM_MASTERS-1:0]      o_grant,
    output logic                        o_busy
);

    localparam int SW = DW / 8;
    localparam int IW = $clog2(NUM_MASTERS);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state, state_nxt;
    logic [NUM_MASTERS-1:0] grant, grant_nxt;
    logic [IW-1:0]          ptr, ptr_nxt;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic [IW-1:0]          gidx;
    logic [IW-1:0]          win_idx;
    logic                   timeout_hit;
    logic                   done;

    // Index of the granted master, recovered from the one-hot grant register.
    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant[i]) gidx = IW'(i);
        end
    end

    // Descending scan so the last hit, i.e. the first in search order, wins.
    always_comb begin
        win_idx = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (RR_MODE != 0) begin
                if (i_m_cyc[(int'(ptr) + k) % NUM_MASTERS])
                    win_idx = IW'((int'(ptr) + k) % NUM_MASTERS);
            end else if (i_m_cyc[k]) begin
                win_idx = IW'(k);
            end
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
    assign o_grant     = grant;
    assign o_m_rdt     = i_sram_rdata;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        ptr_nxt      = ptr;
        cnt_nxt      = cnt;
        done         = 1'b0;
        o_m_ack      = '0;
        o_m_err      = '0;
        o_sram_addr  = '0;
        o_sram_wdata = '0;
        o_sram_wmask = '0;
        o_sram_we    = 1'b0;
        o_sram_cs    = 1'b0;
        o_busy       = 1'b0;
        case (state)
            IDLE: begin
                if (|i_m_cyc) begin
                    grant_nxt = NUM_MASTERS'(1) << win_idx;
                    cnt_nxt   = '0;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                o_busy       = 1'b1;
                o_sram_cs    = 1'b1;
                o_sram_addr  = i_m_adr[gidx*AW +: AW] >> ADDR_SHIFT;
                o_sram_wdata = i_m_dat[gidx*DW +: DW];
                o_sram_wmask = i_m_sel[gidx*SW +: SW];
                o_sram_we    = i_m_we[gidx];
                // Ack beats both abort and expiry; an aborted master gets no err.
                if (i_sram_ack) begin
                    o_m_ack = grant;
                    done    = 1'b1;
                end else if (!i_m_cyc[gidx]) begin
                    done = 1'b1;
                end else if (timeout_hit) begin
                    o_m_err = grant;
                    done    = 1'b1;
                end else if (TIMEOUT != 0) begin
                    cnt_nxt = cnt + 1'b1;
                end
                if (done) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    ptr_nxt   = (gidx == IW'(NUM_MASTERS - 1)) ? '0 : gidx + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
        end
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Parametrised N-master arbiter between SERV-style Wishbone-lite request ports (instruction bus, data bus, and future DMA/debug masters) and the single-port on-chip SRAM. It replaces the fixed two-master combinational arbitration with the following:
- A registered, one-hot grant held for the whole transfer.
- Selectable round-robin or fixed-priority arbitration.
- Configurable byte-to-word address translation.
- A bus-timeout watchdog that terminates hung transfers with an error pulse.

## Interface
Parameters:
- NUM_MASTERS, 2: number of request ports (≥2; index 0 is highest fixed priority).
- AW, 32: address width on master and SRAM sides.
- DW, 32: data width; byte-select width SW = DW/8.
- ADDR_SHIFT, 2: right shift applied to the master byte address to form the SRAM word address.
- RR_MODE, 1: 1 = round-robin arbitration, 0 = fixed priority.
- TIMEOUT, 255: number of cycles in BUSY without an ack before an error is raised; 0 disables the watchdog.

Ports (master i occupies slice [i*W +: W] of each flattened bus):
- clk  in  1  system clock, rising edge.
- i_rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- i_m_cyc  in  NUM_MASTERS  per-master request, held until ack/err.
- i_m_we  in  NUM_MASTERS  per-master write enable.
- i_m_adr  in  NUM_MASTERS*AW  per-master byte address.
- i_m_dat  in  NUM_MASTERS*DW  per-master write data.
- i_m_sel  in  NUM_MASTERS*SW  per-master byte enables.
- o_m_rdt  out  DW  read data, broadcast to all masters (= i_sram_rdata).
- o_m_ack  out  NUM_MASTERS  one-cycle completion pulse to the granted master.
- o_m_err  out  NUM_MASTERS  one-cycle timeout pulse to the granted master.
- o_sram_addr  out  AW  word address.
- o_sram_wdata  out  DW  write data.
- o_sram_wmask  out  SW  byte write mask.
- o_sram_we  out  1  write strobe.
- o_sram_cs  out  1  SRAM select.
- i_sram_rdata  in  DW  SRAM read data.
- i_sram_ack  in  1  SRAM completion.
- o_grant  out  NUM_MASTERS  registered one-hot grant (all-zero when idle).
- o_busy  out  1  high in BUSY.

## Operation
- FSM with two states, IDLE and BUSY.
- **IDLE**: if any i_m_cyc is high, select a winner, register o_grant, load the timeout counter to 0, and go to BUSY. Otherwise stay in IDLE.
- **Arbitration**:
  - Fixed priority: the lowest asserted index wins.
  - Round-robin: search starts at pointer ptr and wraps modulo NUM_MASTERS. ptr becomes (g+1) mod N when master g's transfer ends (ack, err or abort).
  - ptr is unchanged while IDLE.
- **BUSY**, granted index g:
  - o_sram_cs = 1.
  - o_sram_addr = i_m_adr[g] >> ADDR_SHIFT, zero-filled.
  - o_sram_wdata = i_m_dat[g].
  - o_sram_wmask = i_m_sel[g].
  - o_sram_we = i_m_we[g].
- **Completion**:
  - i_sram_ack in BUSY asserts o_m_ack[g] combinationally in the same cycle.
  - Next state is IDLE and o_grant clears.
- **Timeout**:
  - The counter increments each BUSY cycle without ack.
  - When it equals TIMEOUT-1 and ack is absent: o_m_err[g] = 1 for that cycle, then return to IDLE.
  - Ack in the same cycle as expiry wins; no err is raised.
- **Abort**: if i_m_cyc[g] falls while BUSY with no ack, return to IDLE with no ack and no err. SRAM outputs are still driven in that cycle.
- Outside BUSY, all o_sram_* outputs, o_m_ack and o_m_err are 0.
- i_sram_ack in IDLE is ignored.
- Requests from non-granted masters are never acked; they wait with cyc held.

## Timing
- **Reset** (i_rst_n low at a clock edge): state IDLE, o_grant 0, ptr 0, counter 0. All outputs read 0 from the cycle after the reset edge; o_m_rdt follows i_sram_rdata.
- **Reset mid-transfer**: the transfer is dropped with no ack/err, and cs falls after the edge.
- **Request latency**: cyc high in cycle 0 (IDLE) gives grant/cs in cycle 1. Earliest ack is in cycle 1; IDLE is re-entered in cycle 2.
- **Minimum per-transfer occupancy**: 2 cycles. One IDLE cycle always separates transfers, including back-to-back transfers from the same master.
- **Simultaneous requests**: resolved in a single IDLE cycle; exactly one grant bit is set.
- **Watchdog**: with TIMEOUT=T, err fires in the T-th BUSY cycle. With TIMEOUT=0, BUSY persists until ack or abort.
- **Counter width**: clog2(TIMEOUT+1), with no wrap.

## Test plan
- **Single master read**: N=2; m1 reads byte address 0x0000_0010 and SRAM acks in 1 cycle. Required: o_sram_addr=0x4, cs in cycle 1, o_m_ack=2'b10 in cycle 1 with o_m_rdt = i_sram_rdata, grant clears in cycle 2.
- **Round-robin fairness**: N=3, RR_MODE=1, all cyc held continuously, SRAM acks immediately. Required: grant order 001→010→100→001, with an idle cycle between each grant.
- **Fixed priority**: RR_MODE=0, m0 and m2 request continuously. Required: m0 is granted every time and m2 is starved. When m0 drops, m2 is granted in the next IDLE cycle.
- **Write path**: m0 writes sel=4'b0011, dat=0xDEADBEEF, adr=0x100. Required: o_sram_we=1, o_sram_wmask=0011, o_sram_wdata=0xDEADBEEF, o_sram_addr=0x40.
- **Timeout vs. late ack**: TIMEOUT=4, SRAM never acks.
  - Required: o_m_err[g] pulses in the 4th BUSY cycle, then IDLE, and ptr advances.
  - Repeat with ack in the 4th cycle: ack is raised, no err.
- **Abort and reset**: the granted master drops cyc mid-wait → IDLE with no ack. Separately, assert i_rst_n=0 during BUSY → all outputs 0 and grant 0 after the edge.
